trigger_network_controller: RTL and testbench

- Network-level scheduler for a bank of per-actor trigger FSMs.
- Starts all enabled triggers together and builds the global all_sleep / all_sync / all_sync_wait consensus signals from the per-trigger status outputs.
- Detects network quiescence and signals completion to the host-facing ap_* handshake.
- Counts synchronisation rounds and enforces an optional cycle watchdog.

---
 rtl/trigger_network_controller_pkg.sv | 12 +
 rtl/trigger_network_controller_consensus.sv | 27 ++
 rtl/trigger_network_controller.sv | 140 ++++++++++++++
 tb/tb_trigger_network_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_network_controller_pkg.sv
// Shared types for the trigger network controller.
package trigger_network_controller_pkg;

  // Network-level run phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/trigger_network_controller_consensus.sv
// Masked AND-reduction of one per-trigger status vector with a single
// output register; disabled triggers never block the consensus.
module trigger_consensus #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [N-1:0] i_bits,
  input  logic [N-1:0] i_mask,
  output logic         o_q
);
  logic w_d;
  logic r_q;

  assign w_d = &(i_bits | ~i_mask);

  // Capture the reduction only while enabled so the first enabled cycle reads 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_q <= 1'b0;
    else          r_q <= i_en & w_d;
  end

  // Gate with enable so the broadcast drops as soon as the run ends or reset hits.
  assign o_q = r_q & i_en;

endmodule

// File: rtl/trigger_network_controller.sv
// Network scheduler: starts enabled triggers, builds the global consensus
// broadcasts, counts sync rounds, detects quiescence and runs a watchdog.
module trigger_network_controller
  import trigger_network_controller_pkg::*;
#(
  parameter int NUM_ACTORS     = 4,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_ready,
  output logic                  ap_idle,
  input  logic [NUM_ACTORS-1:0] actor_mask,
  output logic [NUM_ACTORS-1:0] trig_start,
  input  logic [NUM_ACTORS-1:0] trig_idle,
  input  logic [NUM_ACTORS-1:0] trig_sleep,
  input  logic [NUM_ACTORS-1:0] trig_sync_exec,
  input  logic [NUM_ACTORS-1:0] trig_sync_wait,
  output logic                  all_sleep,
  output logic                  all_sync,
  output logic                  all_sync_wait,
  output logic [CNT_W-1:0]      sync_rounds,
  output logic                  timed_out
);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam int               TO_M1   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_M1);
  localparam logic             WD_EN   = (TIMEOUT_CYCLES > 0);

  ctrl_state_t             r_state, w_next;
  logic [NUM_ACTORS-1:0]   r_mask_q;
  logic                    r_first;
  logic [CNT_W-1:0]        r_cycles;
  logic [CNT_W-1:0]        r_rounds;
  logic                    r_timed_out;
  logic                    r_sync_prev;

  logic                    w_run, w_accept, w_all_idle, w_complete, w_timeout;
  logic [NUM_ACTORS-1:0]   w_sync_any;

  assign w_run      = (r_state == RUN);
  assign w_accept   = (r_state == IDLE) && ap_start;
  assign w_all_idle = &(trig_idle | ~r_mask_q);
  // Triggers are still leaving IDLE during the first RUN cycle, so skip it.
  assign w_complete = w_run && !r_first && w_all_idle;
  assign w_timeout  = WD_EN && w_run && (r_cycles == TO_LAST);
  assign w_sync_any = trig_sync_exec | trig_sync_wait;

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= IDLE;
    else           r_state <= w_next;
  end

  // Next-state logic; completion is checked before the watchdog so it wins a tie.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (ap_start) w_next = (actor_mask == '0) ? DONE : START;
      START: w_next = RUN;
      RUN:   if (w_complete || w_timeout) w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Host handshake and trigger start are pure decodes of the state.
  always_comb begin
    ap_idle    = 1'b0;
    ap_done    = 1'b0;
    trig_start = '0;
    case (r_state)
      IDLE:  ap_idle    = 1'b1;
      START: trig_start = r_mask_q;
      DONE:  ap_done    = 1'b1;
      default: ;
    endcase
  end

  assign ap_ready = ap_done;

  // Mask capture and first-RUN-cycle marker.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_mask_q <= '0;
      r_first  <= 1'b0;
    end else begin
      if (w_accept) r_mask_q <= actor_mask;
      r_first <= (r_state == START);
    end
  end

  // Watchdog cycle counter and sticky abort flag, cleared on each accepted start.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_cycles    <= '0;
      r_timed_out <= 1'b0;
    end else if (w_accept) begin
      r_cycles    <= '0;
      r_timed_out <= 1'b0;
    end else begin
      if (WD_EN && w_run) r_cycles <= r_cycles + CNT_ONE;
      if (w_timeout && !w_complete) r_timed_out <= 1'b1;
    end
  end

  // Round counter: one count per rising edge of the registered all_sync, saturating.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rounds    <= '0;
      r_sync_prev <= 1'b0;
    end else begin
      r_sync_prev <= all_sync;
      if (w_accept) r_rounds <= '0;
      else if (all_sync && !r_sync_prev && (r_rounds != '1)) r_rounds <= r_rounds + CNT_ONE;
    end
  end

  assign sync_rounds = r_rounds;
  assign timed_out   = r_timed_out;

  trigger_consensus #(.N(NUM_ACTORS)) u_sleep (
    .i_clk(ap_clk), .i_rst_n(ap_rst_n), .i_en(w_run),
    .i_bits(trig_sleep), .i_mask(r_mask_q), .o_q(all_sleep)
  );

  trigger_consensus #(.N(NUM_ACTORS)) u_sync (
    .i_clk(ap_clk), .i_rst_n(ap_rst_n), .i_en(w_run),
    .i_bits(w_sync_any), .i_mask(r_mask_q), .o_q(all_sync)
  );

  trigger_consensus #(.N(NUM_ACTORS)) u_sync_wait (
    .i_clk(ap_clk), .i_rst_n(ap_rst_n), .i_en(w_run),
    .i_bits(trig_sync_wait), .i_mask(r_mask_q), .o_q(all_sync_wait)
  );

endmodule

// File: tb/tb_trigger_network_controller.sv
// Scoreboard bench: the driver plans each run from the consensus rules and
// queues per-cycle and per-run expectations; a negedge monitor checks them.
module tb_trigger_network_controller;
  localparam int NA = 4;
  localparam int TO = 20;
  localparam int CW = 32;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n, ap_start, ap_done, ap_ready, ap_idle;
  logic [NA-1:0] actor_mask, trig_start, trig_idle, trig_sleep, trig_sync_exec, trig_sync_wait;
  logic          all_sleep, all_sync, all_sync_wait, timed_out;
  logic [CW-1:0] sync_rounds;

  trigger_network_controller #(.NUM_ACTORS(NA), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
    .ap_ready(ap_ready), .ap_idle(ap_idle), .actor_mask(actor_mask), .trig_start(trig_start),
    .trig_idle(trig_idle), .trig_sleep(trig_sleep), .trig_sync_exec(trig_sync_exec),
    .trig_sync_wait(trig_sync_wait), .all_sleep(all_sleep), .all_sync(all_sync),
    .all_sync_wait(all_sync_wait), .sync_rounds(sync_rounds), .timed_out(timed_out)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic idle; logic done; logic [3:0] ts; logic s; logic y; logic w; logic to; logic [31:0] rnd;
  } cyc_t;
  typedef struct packed { logic [31:0] rnd; logic to; } txn_t;

  cyc_t q_cyc[$];
  txn_t q_txn[$];
  int   nchk = 0, npass = 0;
  logic [3:0] idl[1:TO], slp[1:TO], sx[1:TO], sw[1:TO];
  int   m_rounds;
  logic m_to;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic push(input logic idle, input logic done, input logic [3:0] ts,
                      input logic s, input logic y, input logic w);
    cyc_t e;
    e.idle = idle; e.done = done; e.ts = ts; e.s = s; e.y = y; e.w = w;
    e.to = m_to; e.rnd = 32'(m_rounds);
    q_cyc.push_back(e);
  endtask

  task automatic tick();
    @(posedge ap_clk); #1;
  endtask

  function automatic logic andm(input logic [3:0] v, input logic [3:0] m);
    return &(v | ~m);
  endfunction

  // Per-cycle checks plus one per-run scoreboard entry popped on ap_done.
  always @(negedge ap_clk) begin
    cyc_t e;
    txn_t t;
    if (q_cyc.size() > 0) begin
      e = q_cyc.pop_front();
      chk("ap_idle", 32'(ap_idle), 32'(e.idle));
      chk("ap_done", 32'(ap_done), 32'(e.done));
      chk("ap_ready", 32'(ap_ready), 32'(e.done));
      chk("trig_start", 32'(trig_start), 32'(e.ts));
      chk("all_sleep", 32'(all_sleep), 32'(e.s));
      chk("all_sync", 32'(all_sync), 32'(e.y));
      chk("all_sync_wait", 32'(all_sync_wait), 32'(e.w));
      chk("timed_out", 32'(timed_out), 32'(e.to));
      chk("sync_rounds", sync_rounds, e.rnd);
    end
    if (ap_done === 1'b1) begin
      if (q_txn.size() == 0) begin
        nchk++;
        $display("FAIL done_unexpected: ap_done=1 with no run outstanding at %0t", $time);
      end else begin
        t = q_txn.pop_front();
        chk("run_rounds", sync_rounds, t.rnd);
        chk("run_timed_out", 32'(timed_out), 32'(t.to));
      end
    end
  end

  task automatic clr_script();
    for (int r = 1; r <= TO; r++) begin
      idl[r] = '0; slp[r] = '0; sx[r] = '0; sw[r] = '0;
    end
  endtask

  task automatic idle_cyc();
    ap_start = 1'b0;
    push(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  // One network run: IDLE request, START, RUN cycles from the script, DONE.
  task automatic run_one(input logic [3:0] m, input int rst_at);
    logic pS, pY, pW, sp, done_now, to_now;
    txn_t t;
    ap_start = 1'b1; actor_mask = m;
    trig_idle = '1; trig_sleep = '0; trig_sync_exec = '0; trig_sync_wait = '0;
    push(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    m_rounds = 0; m_to = 1'b0;
    if (m == 4'h0) begin
      ap_start = 1'($urandom); actor_mask = 4'($urandom);
      push(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
      t.rnd = 0; t.to = 1'b0; q_txn.push_back(t);
      tick();
      return;
    end
    ap_start = 1'($urandom); actor_mask = 4'($urandom);
    push(1'b0, 1'b0, m, 1'b0, 1'b0, 1'b0);
    tick();
    pS = 0; pY = 0; pW = 0; sp = 0;
    for (int r = 1; r <= TO; r++) begin
      trig_idle = idl[r]; trig_sleep = slp[r]; trig_sync_exec = sx[r]; trig_sync_wait = sw[r];
      ap_start = 1'($urandom); actor_mask = 4'($urandom);
      if (r == rst_at) begin
        ap_rst_n = 1'b0;
        #1;
        chk("rst_trig_start", 32'(trig_start), 32'h0);
        chk("rst_all_sleep", 32'(all_sleep), 32'h0);
        chk("rst_all_sync", 32'(all_sync), 32'h0);
        chk("rst_all_sync_wait", 32'(all_sync_wait), 32'h0);
        chk("rst_ap_idle", 32'(ap_idle), 32'h1);
        chk("rst_sync_rounds", sync_rounds, 32'h0);
        m_rounds = 0; m_to = 1'b0;
        push(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        ap_rst_n = 1'b1; ap_start = 1'b0;
        return;
      end
      push(1'b0, 1'b0, 4'h0, pS, pY, pW);
      done_now = (r >= 2) && andm(idl[r], m);
      to_now   = (r == TO);
      if (pY && !sp) m_rounds++;
      sp = pY;
      pS = andm(slp[r], m);
      pY = andm(sx[r] | sw[r], m);
      pW = andm(sw[r], m);
      tick();
      if (done_now || to_now) begin
        m_to = !done_now;
        break;
      end
    end
    trig_idle = '1; ap_start = 1'($urandom);
    push(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    t.rnd = 32'(m_rounds); t.to = m_to; q_txn.push_back(t);
    tick();
  endtask

  initial begin
    ap_rst_n = 1'b1; ap_start = 1'b0; actor_mask = '0;
    trig_idle = '1; trig_sleep = '0; trig_sync_exec = '0; trig_sync_wait = '0;
    m_rounds = 0; m_to = 1'b0;
    #2 ap_rst_n = 1'b0;
    #1;
    chk("reset_ap_idle", 32'(ap_idle), 32'h1);
    chk("reset_ap_done", 32'(ap_done), 32'h0);
    chk("reset_trig_start", 32'(trig_start), 32'h0);
    chk("reset_all_sync", 32'(all_sync), 32'h0);
    chk("reset_sync_rounds", sync_rounds, 32'h0);
    chk("reset_timed_out", 32'(timed_out), 32'h0);
    tick(); tick();
    ap_rst_n = 1'b1;
    idle_cyc();

    // Full mask, network goes quiet at RUN cycle 10.
    clr_script(); idl[10] = 4'hF;
    run_one(4'hF, 0); idle_cyc();

    // Partial mask: sleep consensus rises then falls; bits 1 and 3 ignored.
    clr_script();
    for (int r = 1; r <= 5; r++) slp[r] = 4'b0101;
    for (int r = 6; r <= 9; r++) slp[r] = 4'b0001;
    idl[10] = 4'b0101;
    run_one(4'b0101, 0); idle_cyc();

    // Three sync pulses, the last held 5 cycles; idle in RUN cycle 1 is ignored.
    clr_script(); idl[1] = 4'hF;
    sx[2] = 4'hF; sx[5] = 4'b0011; sw[5] = 4'b1100;
    for (int r = 8; r <= 12; r++) sx[r] = 4'hF;
    idl[15] = 4'hF;
    run_one(4'hF, 0); idle_cyc();

    // Watchdog abort, then a tie of completion and timeout (completion wins).
    clr_script();
    run_one(4'hF, 0); idle_cyc(); idle_cyc();
    clr_script(); idl[TO] = 4'hF;
    run_one(4'hF, 0); idle_cyc();

    // Empty mask finishes without starting anything.
    run_one(4'h0, 0); idle_cyc();

    // Reset mid-run with every consensus high.
    clr_script();
    for (int r = 1; r <= TO; r++) begin slp[r] = 4'hF; sx[r] = 4'hF; sw[r] = 4'hF; end
    run_one(4'hF, 5); idle_cyc();

    // Randomised runs.
    for (int k = 0; k < 40; k++) begin
      for (int r = 1; r <= TO; r++) begin
        idl[r] = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom);
        slp[r] = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
        sx[r]  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
        sw[r]  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      end
      run_one(4'($urandom_range(0, 15)),
              ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, TO)) : 0);
      idle_cyc();
    end

    idle_cyc(); idle_cyc();
    chk("cycle_queue_drained", 32'(q_cyc.size()), 32'h0);
    chk("runs_completed", 32'(q_txn.size()), 32'h0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
